// File: rtl/div_64_32_seq.sv
// Sequential signed divider: 2*DW-bit dividend / DW-bit divisor, radix-2 restoring on magnitudes.
// One quotient bit per clock, truncating toward zero; remainder carries the dividend's sign.
module div_64_32_seq #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            ovf,
    output logic            dz
);

    localparam int CW = $clog2(2*DW) + 1;
    localparam logic [CW-1:0] LAST = CW'(2*DW-1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic            sa, sb, dz_op;
    logic [2*DW-1:0] dvd, dvd_nxt;
    logic [DW:0]     rem, rem_sh, rem_nxt;
    logic [DW-1:0]   dsr;

    // Unsigned magnitude; 2*DW bits keeps |-2^(2DW-1)| exact.
    function automatic logic [2*DW-1:0] mag_wide(input logic signed [2*DW-1:0] v);
        return v[2*DW-1] ? -v : v;
    endfunction

    function automatic logic [DW-1:0] neg_if(input logic [DW-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    // A negative quotient may reach 2^(DW-1); a positive one only 2^(DW-1)-1.
    function automatic logic q_ovf(input logic [2*DW-1:0] qmag, input logic qneg);
        logic [2*DW-1:0] lim;
        lim = (2*DW)'(1) << (DW-1);
        if (!qneg) lim = lim - (2*DW)'(1);
        return qmag > lim;
    endfunction

    assign busy = (state != S_IDLE);

    // Restoring step: quotient bits shift into the low end of dvd as dividend bits leave the top.
    always_comb begin
        rem_sh  = {rem[DW-1:0], dvd[2*DW-1]};
        dvd_nxt = {dvd[2*DW-2:0], 1'b0};
        rem_nxt = rem_sh;
        if (rem_sh >= {1'b0, dsr}) begin
            rem_nxt    = rem_sh - {1'b0, dsr};
            dvd_nxt[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            sa    <= dividend[2*DW-1];
            sb    <= divisor[DW-1];
            dz_op <= (divisor == '0);
            dvd   <= (divisor == '0) ? dividend : mag_wide(dividend);
            dsr   <= divisor[DW-1] ? -divisor : divisor;
            rem   <= '0;
        end else if (state == S_RUN) begin
            rem <= rem_nxt;
            dvd <= dvd_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            count     <= '0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count <= '0;
                        state <= (divisor == '0) ? S_FIX : S_RUN;
                    end
                end
                S_RUN: begin
                    count <= count + CW'(1);
                    if (count == LAST) state <= S_FIX;
                end
                S_FIX: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                    dz    <= dz_op;
                    if (dz_op) begin
                        quotient  <= '1;
                        remainder <= dvd[DW-1:0];
                        ovf       <= 1'b0;
                    end else begin
                        quotient  <= neg_if(dvd[DW-1:0], sa ^ sb);
                        remainder <= neg_if(rem[DW-1:0], sa);
                        ovf       <= q_ovf(dvd, sa ^ sb);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_64_32_seq.sv
// Directed bench for div_64_32_seq: sign matrix, overflow edges, divide-by-zero,
// ignored start while busy, and reset mid-operation.
module tb_div_64_32_seq;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        busy, done, ovf, dz;
    logic [31:0] quotient, remainder;

    int checks = 0;
    int errors = 0;
    int lat;
    int extra_done;

    div_64_32_seq #(.DW(32)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .ovf(ovf), .dz(dz)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one op from an IDLE cycle and wait (bounded) for done; lat = clocks after E0.
    task automatic run_op(input logic [63:0] a, input logic [31:0] b, output int l);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        l = 0;
        while (!done && l < 200) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic chk_res(input string tag, input int l, input int el, input logic [31:0] q,
                           input logic [31:0] r, input logic o, input logic z);
        chk({tag, "_lat"}, 64'(l), 64'(el));
        chk({tag, "_q"},   64'(quotient), 64'(q));
        chk({tag, "_r"},   64'(remainder), 64'(r));
        chk({tag, "_ovf"}, 64'(ovf), 64'(o));
        chk({tag, "_dz"},  64'(dz), 64'(z));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_q",    64'(quotient), 64'd0);
        chk("rst_r",    64'(remainder), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(64'd100, 32'd7, lat);
        chk_res("pp", lat, 65, 32'd14, 32'd2, 1'b0, 1'b0);
        chk("idle_busy", 64'(busy), 64'd0);
        // back-to-back: each next op starts in the done cycle
        run_op(64'hFFFF_FFFF_FFFF_FF9C, 32'd7, lat);
        chk_res("np", lat, 65, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op(64'd100, 32'hFFFF_FFF9, lat);
        chk_res("pn", lat, 65, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FF9C, 32'hFFFF_FFF9, lat);
        chk_res("nn", lat, 65, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0);

        run_op(64'h4000_0000_0000_0000, 32'h8000_0000, lat);
        chk_res("rt_min", lat, 65, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        run_op(64'h4000_0000_0000_0000, 32'h7FFF_FFFF, lat);
        chk_res("rt_ovf", lat, 65, 32'h8000_0001, 32'd1, 1'b1, 1'b0);
        run_op(64'h8000_0000_0000_0000, 32'hFFFF_FFFF, lat);
        chk_res("min64", lat, 65, 32'd0, 32'd0, 1'b1, 1'b0);
        run_op(64'hFFFF_FFFF_8000_0000, 32'd1, lat);
        chk_res("min32", lat, 65, 32'h8000_0000, 32'd0, 1'b0, 1'b0);

        run_op(64'h0000_0001_DEAD_BEEF, 32'd0, lat);
        chk_res("dz", lat, 1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, 1'b1);
        run_op(64'd100, 32'd7, lat);
        chk_res("dz_clr", lat, 65, 32'd14, 32'd2, 1'b0, 1'b0);

        // start pulsed while busy must not re-latch or queue
        @(posedge clk); #1;
        dividend = 64'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("ign_busy", 64'(busy), 64'd1);
        dividend = 64'd50; divisor = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 10;
        while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
        chk_res("ign", lat, 65, 32'd333, 32'd1, 1'b0, 1'b0);
        extra_done = 0;
        repeat (70) begin @(posedge clk); #1; if (done) extra_done++; end
        chk("ign_one_done", 64'(extra_done), 64'd0);

        // reset 30 clocks into an op
        dividend = 64'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_q",    64'(quotient), 64'd0);
        chk("mid_r",    64'(remainder), 64'd0);
        extra_done = 0;
        repeat (70) begin @(posedge clk); #1; if (done) extra_done++; end
        chk("mid_no_done", 64'(extra_done), 64'd0);
        run_op(64'd100, 32'd7, lat);
        chk_res("post_rst", lat, 65, 32'd14, 32'd2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
